// File: rtl/barrel_shifter_pipe_if.sv
// rtl/barrel_shifter_pipe_if.sv - operand/result handshake bundle for the pipelined barrel shifter
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_carry;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_carry
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_carry
    );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - log2(WIDTH)-stage rotate/shift pipeline with valid/ready flow control
module barrel_shifter_pipe #(
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    barrel_shifter_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] MODE_ROL = 3'b000;
    localparam logic [2:0] MODE_ROR = 3'b001;
    localparam logic [2:0] MODE_SLL = 3'b010;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_SRA = 3'b100;

    logic [SHW-1:0]   valid_q, valid_d;
    logic [SHW-1:0]   carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] data_q [SHW];
    logic [WIDTH-1:0] data_d [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [SHW-1:0]   amt_d  [SHW];
    logic [2:0]       mode_q [SHW];
    logic [2:0]       mode_d [SHW];

    logic [SHW-1:0]   load;
    logic [SHW-1:0]   src_valid;
    logic [SHW-1:0]   src_carry;
    logic [WIDTH-1:0] src_data [SHW];
    logic [SHW-1:0]   src_amt  [SHW];
    logic [2:0]       src_mode [SHW];
    logic [WIDTH:0]   res      [SHW];

    // One stage step by s. The carry tracks the last bit to leave the word, so the
    // stage that applies the final shift of a transaction fixes the reported carry;
    // a transaction with amount 0 never touches it and keeps 0.
    function automatic logic [WIDTH:0] stage_op(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input logic             en,
        input int               s,
        input logic             c
    );
        logic [SHW-1:0]   il;
        logic [SHW-1:0]   ir;
        logic [WIDTH-1:0] r;
        logic             co;
        il = SHW'(WIDTH - s);
        ir = SHW'(s - 1);
        r  = d;
        co = c;
        if (en) begin
            case (mode)
                MODE_ROL: begin
                    r  = (d << s) | (d >> (WIDTH - s));
                    co = r[0];
                end
                MODE_ROR: begin
                    r  = (d >> s) | (d << (WIDTH - s));
                    co = r[WIDTH-1];
                end
                MODE_SLL: begin
                    r  = d << s;
                    co = d[il];
                end
                MODE_SRL: begin
                    r  = d >> s;
                    co = d[ir];
                end
                MODE_SRA: begin
                    r  = $signed(d) >>> s;
                    co = d[ir];
                end
                default: begin
                    r  = d;
                    co = c;
                end
            endcase
        end
        return {co, r};
    endfunction

    // Stage k sees either the input port (k == 0) or the register of stage k-1.
    always_comb begin
        src_valid    = '0;
        src_carry    = '0;
        src_valid[0] = bus.in_valid;
        src_data[0]  = bus.in_data;
        src_amt[0]   = bus.in_amt;
        src_mode[0]  = bus.in_mode;
        for (int k = 1; k < SHW; k++) begin
            src_valid[k] = valid_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_data[k]  = data_q[k-1];
            src_amt[k]   = amt_q[k-1];
            src_mode[k]  = mode_q[k-1];
        end
    end

    // Ready ripples backwards from the consumer; an empty stage always loads.
    always_comb begin : load_chain
        logic ld;
        ld   = bus.out_ready;
        load = '0;
        for (int k = SHW - 1; k >= 0; k--) begin
            ld      = !valid_q[k] || ld;
            load[k] = ld;
        end
    end

    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            res[k] = stage_op(src_data[k], src_mode[k], src_amt[k][0], 1 << k, src_carry[k]);
        end
    end

    // Residual amount is kept pre-shifted so every stage tests bit 0.
    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        for (int k = 0; k < SHW; k++) begin
            data_d[k] = data_q[k];
            amt_d[k]  = amt_q[k];
            mode_d[k] = mode_q[k];
            if (load[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_d[k]  = res[k][WIDTH-1:0];
                    carry_d[k] = res[k][WIDTH];
                    amt_d[k]   = src_amt[k] >> 1;
                    mode_d[k]  = src_mode[k];
                end
            end
        end
        if (load[SHW-1] && src_valid[SHW-1]) begin
            zero_d = (res[SHW-1][WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            zero_q  <= 1'b0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= data_d[k];
                amt_q[k]  <= amt_d[k];
                mode_q[k] <= mode_d[k];
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];
    assign bus.out_carry = carry_q[SHW-1];
    assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - self-checking bench for barrel_shifter_pipe (WIDTH 8 and 32)
module tb_barrel_shifter_pipe;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    barrel_shifter_pipe_if #(.WIDTH(8))  if8 ();
    barrel_shifter_pipe_if #(.WIDTH(32)) if32 ();

    barrel_shifter_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    barrel_shifter_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

    typedef struct {
        logic [31:0] data;
        logic        c;
        logic        z;
        int          cyc;
    } out_t;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] data;
        logic [2:0] amt;
        logic [7:0] exp_data;
        logic       exp_c;
        logic       exp_z;
    } vec_t;

    out_t q8[$];
    out_t exp32[$];
    int   rcv32 = 0;
    int   last_acc = 0;
    localparam int NRAND = 200;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: each result bit is picked from its source bit by index arithmetic.
    function automatic out_t ref_model(input int w, input logic [31:0] d, input int n, input logic [2:0] mode);
        out_t o;
        o.data = '0;
        for (int i = 0; i < w; i++) begin
            case (mode)
                3'd0: o.data[i] = d[(i - n + w) % w];
                3'd1: o.data[i] = d[(i + n) % w];
                3'd2: o.data[i] = (i - n >= 0) ? d[i - n] : 1'b0;
                3'd3: o.data[i] = (i + n < w) ? d[i + n] : 1'b0;
                3'd4: o.data[i] = (i + n < w) ? d[i + n] : d[w - 1];
                default: o.data[i] = d[i];
            endcase
        end
        o.c = 1'b0;
        if (n != 0) begin
            case (mode)
                3'd0: o.c = o.data[0];
                3'd1: o.c = o.data[w - 1];
                3'd2: o.c = d[w - n];
                3'd3, 3'd4: o.c = d[n - 1];
                default: o.c = 1'b0;
            endcase
        end
        o.z = (o.data == 32'd0);
        o.cyc = 0;
        return o;
    endfunction

    always @(negedge clk) begin
        if (!rst && if8.out_valid && if8.out_ready)
            q8.push_back('{data: {24'd0, if8.out_data}, c: if8.out_carry, z: if8.out_zero, cyc: cyc});
    end

    always @(negedge clk) begin
        if (!rst && if32.out_valid && if32.out_ready) begin
            if (exp32.size() == 0) begin
                check("rand_unexpected_output", 64'd1, 64'd0);
            end else begin
                out_t e;
                e = exp32.pop_front();
                check($sformatf("rand_item%0d", rcv32),
                      {30'd0, if32.out_zero, if32.out_carry, if32.out_data},
                      {30'd0, e.z, e.c, e.data});
            end
            rcv32++;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send8(input logic [2:0] m, input logic [7:0] d, input logic [2:0] a);
        int g = 0;
        if8.in_valid = 1'b1;
        if8.in_mode  = m;
        if8.in_data  = d;
        if8.in_amt   = a;
        @(negedge clk);
        while (!if8.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!if8.in_ready) check("send8_timeout", 64'd0, 64'd1);
        last_acc = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [2:0] m, input logic [31:0] d, input logic [4:0] a, output bit ok);
        int g = 0;
        if32.in_valid = 1'b1;
        if32.in_mode  = m;
        if32.in_data  = d;
        if32.in_amt   = a;
        @(negedge clk);
        while (!if32.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        ok = if32.in_ready;
        if (!ok) check("send32_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q8(input int n);
        int g = 0;
        while (q8.size() < n && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
    endtask

    initial begin
        vec_t tbl[12];
        out_t bp_exp[5];
        logic [2:0] bp_mode[5];
        logic [7:0] bp_data[5];
        logic [2:0] bp_amt[5];
        logic [7:0] snap;
        bit   saw_valid;
        bit   stable;
        int   idx;
        int   acc0;
        int   g;

        tbl[0]  = '{3'b000, 8'h96, 3'd3, 8'hB4, 1'b0, 1'b0};
        tbl[1]  = '{3'b001, 8'h96, 3'd1, 8'h4B, 1'b0, 1'b0};
        tbl[2]  = '{3'b010, 8'h96, 3'd1, 8'h2C, 1'b1, 1'b0};
        tbl[3]  = '{3'b100, 8'h96, 3'd2, 8'hE5, 1'b1, 1'b0};
        tbl[4]  = '{3'b011, 8'h80, 3'd7, 8'h01, 1'b0, 1'b0};
        tbl[5]  = '{3'b011, 8'h01, 3'd1, 8'h00, 1'b1, 1'b1};
        tbl[6]  = '{3'b010, 8'hA5, 3'd0, 8'hA5, 1'b0, 1'b0};
        tbl[7]  = '{3'b111, 8'h3C, 3'd5, 8'h3C, 1'b0, 1'b0};
        tbl[8]  = '{3'b000, 8'h97, 3'd0, 8'h97, 1'b0, 1'b0};
        tbl[9]  = '{3'b100, 8'h7F, 3'd3, 8'h0F, 1'b1, 1'b0};
        tbl[10] = '{3'b001, 8'h01, 3'd1, 8'h80, 1'b1, 1'b0};
        tbl[11] = '{3'b010, 8'h01, 3'd7, 8'h80, 1'b0, 1'b0};

        rst = 1'b1;
        if8.in_valid = 1'b0;  if8.in_data = '0;  if8.in_amt = '0;  if8.in_mode = '0;  if8.out_ready = 1'b1;
        if32.in_valid = 1'b0; if32.in_data = '0; if32.in_amt = '0; if32.in_mode = '0; if32.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out8", {52'd0, if8.out_valid, if8.out_zero, if8.out_carry, 1'b0, if8.out_data}, 64'd0);
        check("reset_out32", {28'd0, if32.out_valid, if32.out_zero, if32.out_carry, 1'b0, if32.out_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {62'd0, if8.in_ready, if32.in_ready}, 64'd3);
        @(posedge clk);
        #1;

        // Table: all rows back-to-back, consumer always ready.
        q8.delete();
        for (int i = 0; i < 12; i++) begin
            send8(tbl[i].mode, tbl[i].data, tbl[i].amt);
            if (i == 0) acc0 = last_acc;
        end
        if8.in_valid = 1'b0;
        wait_q8(12);
        check("tbl_count", q8.size(), 64'd12);
        for (int i = 0; i < 12 && i < q8.size(); i++) begin
            check($sformatf("tbl_row%0d", i), {q8[i].z, q8[i].c, q8[i].data},
                  {tbl[i].exp_z, tbl[i].exp_c, 24'd0, tbl[i].exp_data});
        end
        if (q8.size() >= 12) begin
            check("latency_rol", q8[0].cyc - acc0, 64'd2);
            check("no_gaps", q8[11].cyc - q8[0].cyc, 64'd11);
        end

        // Backpressure: consumer stalled while five inputs are offered.
        bp_mode = '{3'd0, 3'd2, 3'd4, 3'd1, 3'd0};
        bp_data = '{8'h81, 8'h33, 8'hC8, 8'h0F, 8'h5A};
        bp_amt  = '{3'd4, 3'd2, 3'd3, 3'd6, 3'd1};
        for (int i = 0; i < 5; i++) bp_exp[i] = ref_model(8, {24'd0, bp_data[i]}, bp_amt[i], bp_mode[i]);
        q8.delete();
        if8.out_ready = 1'b0;
        idx = 0;
        saw_valid = 1'b0;
        stable = 1'b1;
        snap = '0;
        for (int c = 0; c < 6; c++) begin
            if8.in_valid = (idx < 5);
            if8.in_mode = bp_mode[idx % 5];
            if8.in_data = bp_data[idx % 5];
            if8.in_amt  = bp_amt[idx % 5];
            @(negedge clk);
            if (if8.out_valid) begin
                if (!saw_valid) snap = if8.out_data;
                else if (if8.out_data !== snap) stable = 1'b0;
                saw_valid = 1'b1;
            end
            if (if8.in_ready && idx < 5) idx++;
            @(posedge clk);
            #1;
        end
        check("bp_accepts_before_stall", idx, 64'd3);
        check("bp_in_ready_low", {63'd0, if8.in_ready}, 64'd0);
        check("bp_out_stable", {62'd0, saw_valid, stable}, 64'd3);
        check("bp_nothing_drained", q8.size(), 64'd0);
        if8.out_ready = 1'b1;
        g = 0;
        while (idx < 5 && g < 20) begin
            send8(bp_mode[idx], bp_data[idx], bp_amt[idx]);
            idx++;
            g++;
        end
        if8.in_valid = 1'b0;
        wait_q8(5);
        repeat (4) @(posedge clk);
        #1;
        check("bp_drain_count", q8.size(), 64'd5);
        for (int i = 0; i < 5 && i < q8.size(); i++) begin
            check($sformatf("bp_item%0d", i), {q8[i].z, q8[i].c, q8[i].data},
                  {bp_exp[i].z, bp_exp[i].c, bp_exp[i].data});
        end

        // Reset with two entries in flight.
        q8.delete();
        send8(3'd0, 8'h11, 3'd1);
        send8(3'd3, 8'hF0, 3'd2);
        if8.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset_outputs", {52'd0, if8.out_valid, if8.out_zero, if8.out_carry, 1'b0, if8.out_data}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", {63'd0, if8.in_ready}, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_stale", q8.size(), 64'd0);
        send8(3'd0, 8'h01, 3'd7);
        if8.in_valid = 1'b0;
        wait_q8(1);
        check("post_reset_count", q8.size(), 64'd1);
        if (q8.size() >= 1) check("post_reset_rol", {q8[0].z, q8[0].c, q8[0].data}, {1'b0, 1'b0, 32'h80});

        // Randomised 32-bit stream with a randomly stalling consumer.
        fork
            begin : drv
                for (int i = 0; i < NRAND; i++) begin
                    logic [2:0]  m;
                    logic [31:0] d;
                    logic [4:0]  a;
                    bit ok;
                    if ($urandom_range(0, 4) == 0) begin
                        if32.in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    m = 3'($urandom_range(0, 7));
                    d = $urandom;
                    a = 5'($urandom_range(0, 31));
                    exp32.push_back(ref_model(32, d, int'(a), m));
                    send32(m, d, a, ok);
                    if (!ok) void'(exp32.pop_back());
                end
                if32.in_valid = 1'b0;
            end
            begin : rdy
                int guard = 0;
                while (rcv32 < NRAND && guard < 20000) begin
                    @(posedge clk);
                    #1;
                    if32.out_ready = ($urandom_range(0, 3) != 0);
                    guard++;
                end
                if32.out_ready = 1'b1;
            end
        join
        g = 0;
        while (exp32.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("rand_count", rcv32, NRAND);
        check("rand_leftover", exp32.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, fully pipelined barrel shifter with valid/ready flow control, and the next generation of the team's 4-bit rotate shifter. Supports rotate left/right, logical left/right and arithmetic right on a WIDTH-bit operand, with a per-transaction mode and amount. Produces zero and carry-out flags, and sustains one result per clock. It sits between the CPU operand/decode stage and the ALU result mux; latency is fixed and backpressure-safe.

## Interface
- WIDTH, 32, operand width in bits; power of two, ≥ 4.
- SHW, $clog2(WIDTH), local, not overridable; shift-amount width and pipeline stage count.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all pipeline state.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts the input this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101-111 reserved.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0.
- out_carry  output  1  carry flag (see Operation).

## Operation
- Pipeline of SHW registered stages. Stage k conditionally applies a shift/rotate of 2^k according to amt bit k.
- Each stage register holds: valid, data, residual amount bits, mode, and carry-so-far.
- Function definitions, with n = in_amt:
  - ROL: rotate left by n.
  - ROR: rotate right by n.
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, fill with in_data[WIDTH-1].
- Reserved modes pass in_data through unchanged, with carry 0.
- out_carry rules:
  - n == 0: carry = 0 in every mode.
  - SLL: carry = in_data[WIDTH-n].
  - SRL and SRA: carry = in_data[n-1].
  - ROL: carry = out_data[0].
  - ROR: carry = out_data[WIDTH-1].
- out_zero is computed in the final stage and registered with the data; it is not computed combinationally from out_data.
- Flow control:
  - A transfer occurs when valid & ready are both high on a rising edge, on either port.
  - Stage k loads when it is empty or when stage k+1 (or the output, for the last stage) accepts its contents.
  - in_ready = stage 0 loads this cycle. It is combinational from out_ready through the stage valids; there is no combinational path from in_valid to in_ready.
  - When out_ready is low and out_valid is high:
    - out_data, out_zero and out_carry hold stable.
    - The pipeline fills and no entry is dropped or duplicated.
    - in_ready falls once all SHW stages are valid.
- Order is strictly preserved; input mode and amount are sampled only at the accepting edge.

## Timing
- Reset (asynchronous assert, any cycle): all stage valids = 0, all data/flag registers = 0; out_valid = 0, out_data = 0, out_zero = 0, out_carry = 0.
- Reset is released synchronously by the system. in_ready = 1 in the first cycle after release.
- Reset mid-operation discards every in-flight entry. No result is produced for them.
- Latency: input accepted at edge N, with out_ready held high, yields out_valid = 1 after edge N+SHW-1. That is SHW cycles, counting the accepting edge as cycle 1.
- Throughput: one transaction per clock while out_ready = 1.
- Simultaneous output drain and input accept while full: permitted, with no bubble inserted.
- Bubble collapse: an empty stage always loads, even if downstream is stalled.

## Test plan
- WIDTH=8, latency: ROL 0x96 by 3, out_ready=1 → out_data=0xB4, carry=0, zero=0, out_valid exactly 3 cycles after accept.
- All modes back-to-back, one per clock, WIDTH=8, in order: ROR 0x96 by 1, SLL 0x96 by 1, SRA 0x96 by 2, SRL 0x80 by 7, SRL 0x01 by 1 → results in order:
  - 0x4B / c0
  - 0x2C / c1
  - 0xE5 / c1
  - 0x01 / c0
  - 0x00 / c1 / zero=1
  - No gaps between results.
- Amount zero and reserved mode: SLL 0xA5 by 0 → 0xA5 c0; mode 111 on 0x3C by 5 → 0x3C c0.
- Backpressure: hold out_ready=0 while streaming 5 inputs →
  - in_ready falls after 3 accepts.
  - out_data stays stable.
  - Releasing out_ready drains all 5 in order with no loss or duplicate.
- Reset mid-stream: assert rst with 2 entries in flight → all outputs 0 immediately (asynchronously); after release no stale result appears; a new ROL 0x01 by 7 → 0x80 c0.
- Randomised stream, WIDTH=32, random out_ready → every result matches the reference function and the order is preserved.
